// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 bus writer: command bytes, FSM encoding,
// 50 MHz default timings and small helpers used by the writer.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_EN_HIGH = 3'd3,
    ST_HOLD    = 3'd4,
    ST_EXEC    = 3'd5
  } lcd_state_e;

  localparam int DEF_T_POWERUP = 2_000_000;
  localparam int DEF_T_SETUP   = 4;
  localparam int DEF_T_EN      = 16;
  localparam int DEF_T_HOLD    = 4;
  localparam int DEF_T_EXEC    = 2_000;
  localparam int DEF_T_CLEAR   = 82_000;

  function automatic int lcd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic lcd_is_slow(input logic rs, input logic [7:0] data);
    return (!rs) && (data[7:2] == 6'b000000) && (data != 8'h00);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that parks at zero; o_zero flags the last cycle of a
// timed phase.
module lcd_delay_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Count down toward zero, with load taking priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RST_VALUE;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// HD44780 physical bus stage: one {rs, byte} per handshake, with setup, E-pulse,
// hold and execution times produced by cycle counting.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = DEF_T_POWERUP,
  parameter int T_SETUP   = DEF_T_SETUP,
  parameter int T_EN      = DEF_T_EN,
  parameter int T_HOLD    = DEF_T_HOLD,
  parameter int T_EXEC    = DEF_T_EXEC,
  parameter int T_CLEAR   = DEF_T_CLEAR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int T_MAX = lcd_max(lcd_max(lcd_max(T_POWERUP, T_SETUP), lcd_max(T_EN, T_HOLD)),
                                 lcd_max(T_EXEC, T_CLEAR));
  localparam int CNT_W = $clog2(T_MAX) + 1;

  lcd_state_e       r_state;
  logic             r_req_ready;
  logic             r_busy;
  logic             r_lcd_rs;
  logic             r_lcd_rw;
  logic             r_lcd_en;
  logic [7:0]       r_lcd_data;
  logic             w_accept;
  logic             w_cnt_load;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_cnt_value;

  // r_req_ready is only ever set in IDLE, so it doubles as the state qualifier.
  assign w_accept = req_valid && r_req_ready;

  // Reload the phase counter with N-1 on the edge that enters each timed state.
  always_comb begin
    w_cnt_load  = 1'b0;
    w_cnt_value = '0;
    case (r_state)
      ST_POWERUP: begin
        w_cnt_load = 1'b0;
      end
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_load  = 1'b1;
          w_cnt_value = CNT_W'(T_SETUP - 1);
        end else begin
          w_cnt_load = 1'b0;
        end
      end
      ST_SETUP: begin
        if (w_cnt_zero) begin
          w_cnt_load  = 1'b1;
          w_cnt_value = CNT_W'(T_EN - 1);
        end else begin
          w_cnt_load = 1'b0;
        end
      end
      ST_EN_HIGH: begin
        if (w_cnt_zero) begin
          w_cnt_load  = 1'b1;
          w_cnt_value = CNT_W'(T_HOLD - 1);
        end else begin
          w_cnt_load = 1'b0;
        end
      end
      ST_HOLD: begin
        if (w_cnt_zero) begin
          w_cnt_load  = 1'b1;
          w_cnt_value = lcd_is_slow(r_lcd_rs, r_lcd_data) ? CNT_W'(T_CLEAR - 1)
                                                          : CNT_W'(T_EXEC - 1);
        end else begin
          w_cnt_load = 1'b0;
        end
      end
      ST_EXEC: begin
        w_cnt_load = 1'b0;
      end
      default: begin
        w_cnt_load  = 1'b1;
        w_cnt_value = CNT_W'(T_POWERUP - 1);
      end
    endcase
  end

  lcd_delay_counter #(
    .WIDTH     (CNT_W),
    .RST_VALUE (CNT_W'(T_POWERUP - 1))
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_cnt_load),
    .i_value (w_cnt_value),
    .o_zero  (w_cnt_zero)
  );

  // Bus FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_POWERUP;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b1;
      r_lcd_rs    <= 1'b0;
      r_lcd_rw    <= 1'b0;
      r_lcd_en    <= 1'b0;
      r_lcd_data  <= 8'h00;
    end else begin
      r_lcd_rw <= 1'b0;
      case (r_state)
        ST_POWERUP: begin
          if (w_cnt_zero) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_SETUP;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_lcd_rs    <= req_rs;
            r_lcd_data  <= req_data;
          end
        end
        ST_SETUP: begin
          if (w_cnt_zero) begin
            r_state  <= ST_EN_HIGH;
            r_lcd_en <= 1'b1;
          end
        end
        ST_EN_HIGH: begin
          if (w_cnt_zero) begin
            r_state  <= ST_HOLD;
            r_lcd_en <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (w_cnt_zero) begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_cnt_zero) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_POWERUP;
          r_req_ready <= 1'b0;
          r_busy      <= 1'b1;
          r_lcd_en    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign lcd_rs    = r_lcd_rs;
  assign lcd_rw    = r_lcd_rw;
  assign lcd_en    = r_lcd_en;
  assign lcd_data  = r_lcd_data;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer with short timings; outputs are sampled on
// the falling clock edge, cycle-exact against hand-computed offsets.
module tb_lcd_bus_writer;

  localparam int TP = 10;
  localparam int S  = 2;
  localparam int E  = 3;
  localparam int H  = 2;
  localparam int X  = 5;
  localparam int C  = 20;
  localparam int NF = 13;  // 1+S+E+H+X: accept-to-ready for normal writes
  localparam int NS = 28;  // 1+S+E+H+C: accept-to-ready for clear/home

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  int checks = 0;
  int failures = 0;
  int en_pulses = 0;

  lcd_bus_writer #(
    .T_POWERUP (TP),
    .T_SETUP   (S),
    .T_EN      (E),
    .T_HOLD    (H),
    .T_EXEC    (X),
    .T_CLEAR   (C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .req_ready (req_ready),
    .busy      (busy),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;

  always @(posedge lcd_en) en_pulses++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_rs = 1'b1;
    req_data = 8'h41;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, req_ready, lcd_en, lcd_rs, lcd_rw, lcd_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_values got busy=%b rdy=%b en=%b rs=%b rw=%b data=%h exp 1 0 0 0 0 00",
               busy, req_ready, lcd_en, lcd_rs, lcd_rw, lcd_data);
    end
  endtask

  // Called on the negedge where rst_n was just released (cycle 0).
  task automatic check_powerup(input string tag);
    for (int c = 0; c < TP; c++) begin
      checks++;
      if ({req_ready, lcd_en, busy, lcd_rs, lcd_rw, lcd_data} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
        failures++;
        $display("FAIL %s_wait cycle=%0d got rdy=%b en=%b busy=%b rs=%b data=%h exp 0 0 1 0 00",
                 tag, c, req_ready, lcd_en, busy, lcd_rs, lcd_data);
      end
      @(negedge clk);
    end
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL %s_first_ready cycle=%0d got rdy=%b busy=%b exp 1 0", tag, TP, req_ready, busy);
    end
  endtask

  task automatic test_powerup();
    @(negedge clk);
    rst_n = 1'b1;
    check_powerup("powerup");
  endtask

  // mode 0: drop valid after accept; 1: hold valid (stream); 2: toggle valid with junk while busy.
  task automatic run_transfer(input logic rs, input logic [7:0] d, input int n, input int mode,
                              input string tag);
    logic exp_en;
    req_valid = 1'b1;
    req_rs = rs;
    req_data = d;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_at_k got=%b exp=1", tag, req_ready);
    end
    for (int off = 1; off <= n; off++) begin
      @(negedge clk);
      exp_en = (off >= 1 + S) && (off <= S + E);
      checks++;
      if ({lcd_rs, lcd_data, lcd_en, lcd_rw} !== {rs, d, exp_en, 1'b0}) begin
        failures++;
        $display("FAIL %s_bus off=%0d got rs=%b data=%h en=%b rw=%b exp rs=%b data=%h en=%b rw=0",
                 tag, off, lcd_rs, lcd_data, lcd_en, lcd_rw, rs, d, exp_en);
      end
      checks++;
      if ({req_ready, busy} !== ((off == n) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL %s_ready off=%0d got rdy=%b busy=%b exp rdy=%b", tag, off, req_ready, busy,
                 (off == n));
      end
      if (off == n) begin
        if (mode != 1) req_valid = 1'b0;
      end else if (mode == 0) begin
        req_valid = 1'b0;
      end else if (mode == 2) begin
        req_valid = off[0];
        req_rs = ~rs;
        req_data = ~d ^ off[7:0];
      end
    end
  endtask

  task automatic test_data_write();
    run_transfer(1'b1, 8'h41, NF, 0, "data41");
  endtask

  task automatic test_slow_cmd();
    run_transfer(1'b0, 8'h01, NS, 0, "clear");
    run_transfer(1'b0, 8'h38, NF, 0, "func8b2l");
    run_transfer(1'b0, 8'h02, NS, 0, "home02");
    run_transfer(1'b0, 8'h03, NS, 0, "home03");
    run_transfer(1'b0, 8'h00, NF, 0, "cmd00");
    run_transfer(1'b0, 8'h04, NF, 0, "cmd04");
    run_transfer(1'b1, 8'h01, NF, 0, "data01");
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = en_pulses;
    for (int i = 0; i < 32; i++) begin
      run_transfer(1'b1, 8'h20 + 8'(i), NF, 1, "stream");
    end
    req_valid = 1'b0;
    checks++;
    if (en_pulses - p0 !== 32) begin
      failures++;
      $display("FAIL stream_pulses got=%0d exp=32", en_pulses - p0);
    end
  endtask

  task automatic test_ignore_busy();
    run_transfer(1'b1, 8'h5A, NF, 2, "toggle");
    run_transfer(1'b0, 8'h01, NS, 2, "toggle_clr");
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1;
    req_rs = 1'b1;
    req_data = 8'hC3;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready got=%b exp=1", req_ready);
    end
    repeat (S + 1) @(negedge clk);
    checks++;
    if (lcd_en !== 1'b1) begin
      failures++;
      $display("FAIL midrst_en_before got=%b exp=1", lcd_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, req_ready, lcd_en, lcd_rs, lcd_rw, lcd_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL midrst_values got busy=%b rdy=%b en=%b rs=%b rw=%b data=%h exp 1 0 0 0 0 00",
               busy, req_ready, lcd_en, lcd_rs, lcd_rw, lcd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_powerup("repowerup");
    run_transfer(1'b1, 8'h7E, NF, 0, "post_rst");
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_data_write();
    test_slow_cmd();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
